// File: rtl/fpu_divider.sv
// Multi-cycle binary32 divider, round-to-nearest-even, STB/BUSY handshakes.
// Define FPU_DIV_SUBNORMAL_EN for subnormal support; otherwise flush-to-zero.
module fpu_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        div_input_STB,
  output logic        div_BUSY,
  output logic [31:0] output_div,
  output logic        div_output_STB,
  input  logic        output_module_BUSY
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_UNPACK,
    S_SPECIAL,
    S_NORM_A,
    S_NORM_B,
    S_DIV_INIT,
    S_DIV_ITER,
    S_NORM_OUT,
    S_ROUND,
    S_PACK,
    S_PUT
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               stb_q, stb_d;
  logic [31:0]        out_q, out_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  ea_q, ea_d;
  logic signed [9:0]  eb_q, eb_d;
  logic [23:0]        ma_q, ma_d;
  logic [23:0]        mb_q, mb_d;
  logic signed [9:0]  e_q, e_d;
  logic [26:0]        quo_q, quo_d;
  logic [25:0]        rem_q, rem_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [23:0]        rm_q, rm_d;

  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        a_zero, b_zero;

  assign exp_a  = a_q[30:23];
  assign exp_b  = b_q[30:23];
  assign frac_a = a_q[22:0];
  assign frac_b = b_q[22:0];
  assign a_nan  = (&exp_a) & (|frac_a);
  assign b_nan  = (&exp_b) & (|frac_b);
  assign a_inf  = (&exp_a) & ~(|frac_a);
  assign b_inf  = (&exp_b) & ~(|frac_b);
`ifdef FPU_DIV_SUBNORMAL_EN
  assign a_zero = ~(|exp_a) & ~(|frac_a);
  assign b_zero = ~(|exp_b) & ~(|frac_b);
`else
  assign a_zero = ~(|exp_a);
  assign b_zero = ~(|exp_b);
`endif

  // Rounding datapath, consumed only in S_ROUND.
  logic [26:0]       rq;
  logic              rst_s;
  logic signed [9:0] re;
  logic              rg, rr, rs, rup;
  logic [24:0]       rsum;
  logic [23:0]       rmant;
  logic [25:0]       diff;
  logic signed [9:0] biased;
`ifdef FPU_DIV_SUBNORMAL_EN
  logic [9:0]        sh;
  logic [26:0]       mask;
`endif

  always_comb begin
    rq    = quo_q;
    rst_s = |rem_q;
    re    = e_q;
`ifdef FPU_DIV_SUBNORMAL_EN
    sh    = '0;
    mask  = '0;
    // Below 2^-126: denormalise with sticky before rounding.
    if (e_q < -10'sd126) begin
      sh = 10'(-10'sd126 - e_q);
      if (sh > 10'd26) begin
        rst_s = rst_s | (|rq);
        rq    = '0;
      end else begin
        mask  = (27'd1 << sh) - 27'd1;
        rst_s = rst_s | (|(rq & mask));
        rq    = rq >> sh;
      end
      re = -10'sd126;
    end
`endif
    rg    = rq[2];
    rr    = rq[1];
    rs    = rq[0] | rst_s;
    rup   = rg & (rr | rs | rq[3]);
    rsum  = {1'b0, rq[26:3]} + {24'd0, rup};
    rmant = rsum[23:0];
    if (rsum[24]) begin
      rmant = rsum[24:1];
      re    = re + 10'sd1;
    end
  end

  assign diff   = rem_q - {2'b00, mb_q};
  assign biased = rm_q[23] ? (e_q + 10'sd127) : 10'sd0;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    e_d     = e_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    rm_d    = rm_q;
    case (state_q)
      S_IDLE: begin
        if (div_input_STB) begin
          a_d     = input_a;
          b_d     = input_b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d = a_q[31] ^ b_q[31];
`ifdef FPU_DIV_SUBNORMAL_EN
        ma_d = {|exp_a, frac_a};
        mb_d = {|exp_b, frac_b};
        ea_d = (|exp_a) ? ($signed({2'b00, exp_a}) - 10'sd127)
                        : -10'sd126;
        eb_d = (|exp_b) ? ($signed({2'b00, exp_b}) - 10'sd127)
                        : -10'sd126;
`else
        ma_d = {1'b1, frac_a};
        mb_d = {1'b1, frac_b};
        ea_d = $signed({2'b00, exp_a}) - 10'sd127;
        eb_d = $signed({2'b00, exp_b}) - 10'sd127;
`endif
        state_d = S_SPECIAL;
      end
      S_SPECIAL: begin
        state_d = S_PUT;
        if (a_nan | b_nan) begin
          out_d = 32'h7FC0_0000;
        end else if (a_inf & b_inf) begin
          out_d = 32'h7FC0_0000;
        end else if (a_zero & b_zero) begin
          out_d = 32'h7FC0_0000;
        end else if (a_inf | b_zero) begin
          out_d = {sign_q, 8'hFF, 23'd0};
        end else if (b_inf | a_zero) begin
          out_d = {sign_q, 31'd0};
        end else begin
          state_d = S_NORM_A;
        end
      end
      S_NORM_A: begin
        state_d = S_NORM_B;
`ifdef FPU_DIV_SUBNORMAL_EN
        if (!ma_q[23]) begin
          ma_d    = {ma_q[22:0], 1'b0};
          ea_d    = ea_q - 10'sd1;
          state_d = S_NORM_A;
        end
`endif
      end
      S_NORM_B: begin
        state_d = S_DIV_INIT;
`ifdef FPU_DIV_SUBNORMAL_EN
        if (!mb_q[23]) begin
          mb_d    = {mb_q[22:0], 1'b0};
          eb_d    = eb_q - 10'sd1;
          state_d = S_NORM_B;
        end
`endif
      end
      S_DIV_INIT: begin
        e_d     = ea_q - eb_q;
        rem_d   = {2'b00, ma_q};
        quo_d   = '0;
        cnt_d   = 5'd26;
        state_d = S_DIV_ITER;
      end
      S_DIV_ITER: begin
        if (rem_q >= {2'b00, mb_q}) begin
          quo_d = {quo_q[25:0], 1'b1};
          rem_d = {diff[24:0], 1'b0};
        end else begin
          quo_d = {quo_q[25:0], 1'b0};
          rem_d = {rem_q[24:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_NORM_OUT;
      end
      S_NORM_OUT: begin
        if (!quo_q[26]) begin
          quo_d = {quo_q[25:0], 1'b0};
          e_d   = e_q - 10'sd1;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        rm_d    = rmant;
        e_d     = re;
        state_d = S_PACK;
      end
      S_PACK: begin
        if (biased >= 10'sd255) begin
          out_d = {sign_q, 8'hFF, 23'd0};
`ifndef FPU_DIV_SUBNORMAL_EN
        end else if (biased <= 10'sd0) begin
          out_d = {sign_q, 31'd0};
`endif
        end else begin
          out_d = {sign_q, biased[7:0], rm_q[22:0]};
        end
        state_d = S_PUT;
      end
      S_PUT: begin
        if (!output_module_BUSY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    stb_d  = (state_d == S_PUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sign_q <= sign_d;
    ea_q   <= ea_d;
    eb_q   <= eb_d;
    ma_q   <= ma_d;
    mb_q   <= mb_d;
    e_q    <= e_d;
    quo_q  <= quo_d;
    rem_q  <= rem_d;
    cnt_q  <= cnt_d;
    rm_q   <= rm_d;
  end

  assign div_BUSY       = busy_q;
  assign div_output_STB = stb_q;
  assign output_div     = out_q;

endmodule

// File: tb/tb_fpu_divider.sv
// Bench for fpu_divider: exact-integer quotient model plus scoreboard,
// directed vectors with literal expectations.
module tb_fpu_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        stb_in;
  logic        busy;
  logic [31:0] q;
  logic        stb_out;
  logic        obusy;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_xfer = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_divider dut (
    .clk               (clk),
    .rst               (rst),
    .input_a           (a),
    .input_b           (b),
    .div_input_STB     (stb_in),
    .div_BUSY          (busy),
    .output_div        (q),
    .div_output_STB    (stb_out),
    .output_module_BUSY(obusy)
  );

  // Reference: exact quotient via wide integer division, then rounding.
  function automatic logic [31:0] model(input logic [31:0] x,
                                        input logic [31:0] y);
    int ex, ey, base, e, l, sh, biased, p;
    logic [22:0] fx, fy;
    bit nx, ny, ix, iy, zx, zy, s, half, below, up;
    longint unsigned mx, my, num, n, r, kept, lowmask;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = x[22:0];
    fy = y[22:0];
    s  = x[31] ^ y[31];
    nx = (ex == 255) && (fx != 0);
    ny = (ey == 255) && (fy != 0);
    ix = (ex == 255) && (fx == 0);
    iy = (ey == 255) && (fy == 0);
`ifdef FPU_DIV_SUBNORMAL_EN
    zx = (ex == 0) && (fx == 0);
    zy = (ey == 0) && (fy == 0);
`else
    zx = (ex == 0);
    zy = (ey == 0);
`endif
    if (nx || ny) return 32'h7FC0_0000;
    if (ix && iy) return 32'h7FC0_0000;
    if (zx && zy) return 32'h7FC0_0000;
    if (ix || zy) return {s, 8'hFF, 23'd0};
    if (iy || zx) return {s, 31'd0};
    mx = (ex == 0) ? longint'(fx) : longint'(fx) + 64'h80_0000;
    my = (ey == 0) ? longint'(fy) : longint'(fy) + 64'h80_0000;
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    num  = mx << 40;
    n    = num / my;
    r    = num % my;
    p    = 0;
    for (int i = 0; i < 64; i++) if (n[i]) p = i;
    base = (ex - 127) - (ey - 127) - 40;
    e    = p + base;
    l    = e - 23;
`ifdef FPU_DIV_SUBNORMAL_EN
    if (l < -149) l = -149;
`endif
    sh = l - base;
    if (sh > 62) begin
      kept  = 0;
      half  = 0;
      below = 1;
    end else begin
      kept    = n >> sh;
      half    = n[sh-1];
      lowmask = (64'd1 << (sh - 1)) - 1;
      below   = ((n & lowmask) != 0) || (r != 0);
    end
    up = half && (below || kept[0]);
    kept = kept + (up ? 1 : 0);
    if (kept >= 64'h100_0000) begin
      kept = kept >> 1;
      l    = l + 1;
    end
    if (kept >= 64'h80_0000) begin
      biased = l + 150;
      if (biased >= 255) return {s, 8'hFF, 23'd0};
      if (biased <= 0) return {s, 31'd0};
      return {s, biased[7:0], kept[22:0]};
    end
    return {s, 8'd0, kept[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Scoreboard: inputs change just after posedge, so the negedge view
  // is exactly what the next edge will sample.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (stb_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {31'd0, stb_out}, 32'd0);
        end else begin
          chk("scoreboard", q, exp_q[0]);
          if (!obusy) begin
            void'(exp_q.pop_front());
            n_xfer++;
          end
        end
      end
      if (stb_in && !busy) exp_q.push_back(model(a, b));
    end
  end

  task automatic wait_out(input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (!stb_out && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!stb_out) chk({"timeout_", name}, {31'd0, stb_out}, 32'd1);
  endtask

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] lit, input string name);
    @(posedge clk) #1;
    a      = av;
    b      = bv;
    stb_in = 1'b1;
    @(posedge clk) #1;
    stb_in = 1'b0;
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    wait_out(name);
    chk(name, q, lit);
    chk({name, "_model"}, model(av, bv), lit);
  endtask

  initial begin
    logic [31:0] held;
    int x0, cnt;
    rst    = 1'b1;
    stb_in = 1'b0;
    obusy  = 1'b0;
    a      = '0;
    b      = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_stb", {31'd0, stb_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out", q, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;

    // Operands held on STB while busy are taken only after the hand-off.
    @(posedge clk) #1;
    a      = 32'h4000_0000;
    b      = 32'h4040_0000;
    stb_in = 1'b1;
    @(posedge clk) #1;
    a = 32'h4080_0000;
    b = 32'h40A0_0000;
    wait_out("two_thirds");
    chk("two_thirds", q, 32'h3F2A_AAAB);
    chk("busy_with_result", {31'd0, busy}, 32'd1);
    @(posedge clk) #1;
    @(negedge clk);
    chk("busy_drop", {31'd0, busy}, 32'd0);
    chk("stb_drop", {31'd0, stb_out}, 32'd0);
    @(posedge clk) #1;
    stb_in = 1'b0;
    wait_out("four_fifths");
    chk("four_fifths", q, 32'h3F4C_CCCD);

    do_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "one_by_zero");
    do_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, "zero_by_zero");
    do_op(32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, "neg_by_inf");
    do_op(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
    do_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_by_inf");
    do_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, "neg_by_zero");
    do_op(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, "negzero_num");
    do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, "one_third");
    do_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, "neg_six_by_2");
    do_op(32'h3F80_0000, 32'h3F80_0001, 32'h3F7F_FFFE, "near_one");
    do_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, "unity");
    do_op(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, "overflow");
`ifdef FPU_DIV_SUBNORMAL_EN
    do_op(32'h0080_0000, 32'h4000_0000, 32'h0040_0000, "underflow");
`else
    do_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, "underflow");
`endif

    // Backpressure: result must hold still, then transfer once.
    @(posedge clk) #1;
    obusy = 1'b1;
    do_op(32'h40A0_0000, 32'h4040_0000, 32'h3FD5_5555, "bp_op");
    held = q;
    repeat (10) begin
      @(negedge clk);
      chk("bp_stb", {31'd0, stb_out}, 32'd1);
      chk("bp_hold", q, held);
      chk("bp_busy", {31'd0, busy}, 32'd1);
    end
    x0 = n_xfer;
    @(posedge clk) #1;
    obusy = 1'b0;
    @(posedge clk) #1;
    @(negedge clk);
    chk("bp_stb_drop", {31'd0, stb_out}, 32'd0);
    repeat (5) @(negedge clk);
    chk("bp_one_xfer", 32'(n_xfer - x0), 32'd1);

    // Reset five cycles into an operation aborts it.
    @(posedge clk) #1;
    a      = 32'h40A0_0000;
    b      = 32'h4040_0000;
    stb_in = 1'b1;
    @(posedge clk) #1;
    stb_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_stb", {31'd0, stb_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", q, 32'd0);
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (stb_out) cnt++;
    end
    chk("abort_no_stale", 32'(cnt), 32'd0);

    do_op(32'h4049_0FDB, 32'h402D_F854, model(32'h4049_0FDB, 32'h402D_F854),
          "pi_by_e");
    @(posedge clk) #1;
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
